serial_adder: RTL and testbench

Bit-serial ripple adder that adds two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell with a registered carry. It sits directly upstream of the combinational full-adder cell, sequencing operand bits into it and collecting its Sum/Cout. It trades latency for area in datapaths where a WIDTH-bit parallel adder is too large. A start/busy/done handshake frames each operation.

---
 rtl/serial_adder.sv | 145 ++++++++++++++
 tb/tb_serial_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit operands are added LSB first, one bit per clock,
// through a single full-adder cell with a registered carry.

`timescale 1ns/1ps

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;
    logic             load;
    logic             finish;
    logic             busy_next;
    logic             done_next;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result register fills from the MSB side; a 1-bit result is just the cell output.
    if (WIDTH == 1) begin : g_res_w1
        assign res_next = fa_sum;
    end else begin : g_res_wn
        assign res_next = {fa_sum, res_sr[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control decode; busy/done are precomputed from the next state so they register cleanly
    always_comb begin
        load      = 1'b0;
        finish    = 1'b0;
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state)
            IDLE:    load   = start;
            SHIFT:   finish = last_bit;
            default: ;
        endcase
        busy_next = (state_next == SHIFT);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
        end
    end

    // Operand capture, bit-serial datapath and result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
        end else if (load) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            carry  <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
            if (finish) begin
                Sum  <= res_next;
                Cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 3 and 1: a cycle model with a
// result scoreboard checks every cycle, plus a vector table and corner sequences.

`timescale 1ns/1ps

module tb_serial_adder;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [NDUT];
    logic [31:0] a_s     [NDUT];
    logic [31:0] b_s     [NDUT];
    logic        cin_s   [NDUT];
    logic        busy_s  [NDUT];
    logic        done_s  [NDUT];
    logic        cout_s  [NDUT];
    logic [31:0] sum_s   [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 8 : ((g == 1) ? 3 : 1);
        logic [W-1:0] sum_w;
        serial_adder #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_s[g]),
            .A     (a_s[g][W-1:0]),
            .B     (b_s[g][W-1:0]),
            .Cin   (cin_s[g]),
            .busy  (busy_s[g]),
            .done  (done_s[g]),
            .Sum   (sum_w),
            .Cout  (cout_s[g])
        );
        assign sum_s[g] = 32'(sum_w);
    end

    function automatic int width_of(input int g);
        return (g == 0) ? 8 : ((g == 1) ? 3 : 1);
    endfunction

    function automatic logic [32:0] mask_of(input int g);
        return (33'h1 << width_of(g)) - 33'h1;
    endfunction

    int          errors = 0;
    int          checks = 0;
    int          left   [NDUT];
    logic [32:0] last   [NDUT];
    logic [32:0] expq   [NDUT][$];
    bit          armed  = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: left = cycles until idle after the latest edge (W+1 after accept)
    task automatic model_step();
        for (int g = 0; g < NDUT; g++) begin
            logic [32:0] m;
            logic [32:0] act;
            logic [32:0] e;
            m = mask_of(g);
            if (armed) begin
                if (left[g] == 1 && expq[g].size() > 0) last[g] = expq[g].pop_front();
                check($sformatf("w%0d_busy_done", width_of(g)),
                      {31'b0, busy_s[g], done_s[g]},
                      {31'b0, left[g] >= 2, left[g] == 1});
                act = (33'(cout_s[g]) << width_of(g)) | (33'(sum_s[g]) & m);
                check($sformatf("w%0d_cout_sum", width_of(g)), act, last[g]);
            end
            if (rst) begin
                left[g] = 0;
                expq[g].delete();
                last[g] = '0;
            end else if (armed && left[g] == 0 && start_s[g]) begin
                e = (33'(a_s[g]) & m) + (33'(b_s[g]) & m) + 33'(cin_s[g]);
                expq[g].push_back(e);
                left[g] = width_of(g) + 1;
            end else if (left[g] > 0) begin
                left[g]--;
            end
        end
        if (rst) armed = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int g, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, output logic [31:0] s, output logic co);
        bit got;
        int lat;
        got = 1'b0;
        lat = 0;
        start_s[g] = 1'b1;
        a_s[g]     = a;
        b_s[g]     = b;
        cin_s[g]   = cin;
        tick();
        start_s[g] = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            a_s[g]   = $urandom;
            b_s[g]   = $urandom;
            cin_s[g] = 1'($urandom);
            tick();
            lat++;
            if (done_s[g]) got = 1'b1;
        end
        check($sformatf("w%0d_done_seen", width_of(g)), 33'(got), 33'(1));
        check($sformatf("w%0d_latency", width_of(g)), 33'(lat), 33'(width_of(g)));
        s  = sum_s[g];
        co = cout_s[g];
        tick();
    endtask

    initial begin
        logic [31:0] s;
        logic        co;
        int          ndone;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1;
        for (int g = 0; g < NDUT; g++) begin
            start_s[g] = 1'b0;
            a_s[g]     = '0;
            b_s[g]     = '0;
            cin_s[g]   = 1'b0;
            left[g]    = 0;
            last[g]    = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // WIDTH=8 vector table
        for (int i = 0; i < 8; i++) begin
            run_op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, s, co);
            check($sformatf("vec%0d_sum", i), 33'(s[7:0]), 33'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 33'(co), 33'(vecs[i].cout));
        end

        // start held high: accepts every WIDTH+2 cycles, operands churn every cycle
        ndone = 0;
        start_s[0] = 1'b1;
        for (int i = 0; i < 35; i++) begin
            a_s[0]   = $urandom;
            b_s[0]   = $urandom;
            cin_s[0] = 1'($urandom);
            tick();
            if (done_s[0]) ndone++;
        end
        start_s[0] = 1'b0;
        repeat (12) tick();
        check("held_start_done_count", 33'(ndone), 33'(3));

        // reset in the 4th SHIFT cycle abandons the operation
        start_s[0] = 1'b1;
        a_s[0]     = 32'h77;
        b_s[0]     = 32'h11;
        cin_s[0]   = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_outputs", {busy_s[0], done_s[0], cout_s[0], 22'b0, sum_s[0][7:0]}, 33'(0));
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_s[0]) ndone++;
        end
        check("rst_mid_no_done", 33'(ndone), 33'(0));
        run_op(0, 32'h77, 32'h11, 1'b1, s, co);
        check("after_rst_result", {24'b0, co, s[7:0]}, 33'h089);

        // exhaustive WIDTH=3
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++) begin
                    run_op(1, 32'(a), 32'(b), 1'(c), s, co);
                    check($sformatf("w3_%0d+%0d+%0d", a, b, c),
                          {29'b0, co, s[2:0]}, 33'(a + b + c));
                end

        // exhaustive WIDTH=1
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++) begin
                    run_op(2, 32'(a), 32'(b), 1'(c), s, co);
                    check($sformatf("w1_%0d+%0d+%0d", a, b, c),
                          {31'b0, co, s[0]}, 33'(a + b + c));
                end

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
